// File: rtl/usb_fs_in_rr_arb_pkg.sv
// Shared types for the full-speed IN-endpoint round-robin arbiter.
package usb_fs_in_rr_arb_pkg;

    // Arbiter state encodings, reused by the other USB FS blocks.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    // Endpoint index width; a single endpoint still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_fs_in_rr_arb_if.sv
// Bundle of endpoint-side and engine-side signals around the IN arbiter.
interface usb_fs_in_rr_arb_if
    import usb_fs_in_rr_arb_pkg::*;
#(
    parameter int NUM_IN_EPS = 4,
    parameter int IDX_W      = idx_width(NUM_IN_EPS)
);
    logic [NUM_IN_EPS-1:0]   in_ep_req;
    logic [NUM_IN_EPS-1:0]   in_ep_grant;
    logic [NUM_IN_EPS*8-1:0] in_ep_data;
    logic [7:0]              arb_in_ep_data;
    logic                    pe_busy;
    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;

    // Arbiter side.
    modport slave (
        input  in_ep_req, in_ep_data, pe_busy,
        output in_ep_grant, arb_in_ep_data, grant_valid, grant_idx
    );

    // Endpoints / protocol engine side.
    modport master (
        output in_ep_req, in_ep_data, pe_busy,
        input  in_ep_grant, arb_in_ep_data, grant_valid, grant_idx
    );
endinterface

// File: rtl/usb_fs_in_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 to 0. Rotate, priority-encode, unrotate.
module usb_fs_rr_pick
    import usb_fs_in_rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then add ptr back modulo N.
    always_comb begin
        dbl     = {req_i, req_i};
        rot     = dbl[ptr_i +: N];
        found_o = 1'b0;
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        idx_o = sum[IDX_W-1:0];
    end
endmodule

// File: rtl/usb_fs_in_rr_arb.sv
// Registered round-robin arbiter sharing the IN data path among IN endpoints.
// A grant is held for the whole transfer and while the engine is mid-packet,
// followed by one grant-free release cycle before the next arbitration.
module usb_fs_in_rr_arb
    import usb_fs_in_rr_arb_pkg::*;
#(
    parameter int NUM_IN_EPS = 4,
    parameter int IDX_W      = idx_width(NUM_IN_EPS)
) (
    input  logic               clk,
    input  logic               reset_n,
    usb_fs_in_rr_arb_if.slave  bus
);
    arb_state_e              state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        rr_ptr_d;
    logic [NUM_IN_EPS-1:0]   grant_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    valid_q;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [NUM_IN_EPS-1:0]   pick_onehot;
    logic                    hold;
    logic [7:0]              data_mux;

    usb_fs_rr_pick #(
        .N     (NUM_IN_EPS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (bus.in_ep_req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Winner as one-hot, next pointer after the current holder, and hold condition.
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_onehot[i] = 1'b1;
            end
        end
        if (idx_q == IDX_W'(NUM_IN_EPS - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = idx_q + IDX_W'(1);
        end
        // grant_q is one-hot on idx_q, so this is req[grant_idx].
        hold = (|(grant_q & bus.in_ep_req)) | bus.pe_busy;
    end

    // Arbiter FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    // pe_busy deliberately not consulted: the engine NAKs if no data is ready.
                    if (pick_found) begin
                        grant_q <= pick_onehot;
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        state_q <= ARB_GRANTED;
                    end
                end
                ARB_GRANTED: begin
                    if (!hold) begin
                        grant_q  <= '0;
                        valid_q  <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Zero-latency data mux toward the engine; forced to zero with no grant.
    always_comb begin
        data_mux = 8'h00;
        if (valid_q) begin
            for (int i = 0; i < NUM_IN_EPS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    data_mux = bus.in_ep_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.in_ep_grant    = grant_q;
    assign bus.grant_valid    = valid_q;
    assign bus.grant_idx      = idx_q;
    assign bus.arb_in_ep_data = data_mux;

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Directed, table-driven bench for the IN round-robin arbiter (4 endpoints).
module tb_usb_fs_in_rr_arb;

    logic clk = 1'b0;
    logic reset_n;

    usb_fs_in_rr_arb_if #(.NUM_IN_EPS(4)) bus ();

    usb_fs_in_rr_arb #(.NUM_IN_EPS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       busy;
        logic [3:0] g;
        logic [1:0] i;
        logic [7:0] a;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Append one vector: inputs applied before an edge, outputs expected after it.
    task automatic v(input logic r, input logic [3:0] req, input logic b,
                     input logic [3:0] g, input logic [1:0] i, input logic [7:0] a);
        vec_t t;
        t.rst_n = r; t.req = req; t.busy = b; t.g = g; t.i = i; t.a = a;
        vq.push_back(t);
    endtask

    initial begin
        int n;
        reset_n        = 1'b0;
        bus.in_ep_req  = 4'b0000;
        bus.pe_busy    = 1'b0;
        bus.in_ep_data = 32'hD3C2B1A0;

        // Reset held with all requests high
        repeat (3) v(0, 4'hF, 0, 4'h0, 2'd0, 8'h00);
        // Round-robin: ep0, ep1, ep2, ep3, ep0
        repeat (4) v(1, 4'hF, 0, 4'h1, 2'd0, 8'hA0);
        v(1, 4'hE, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'hF, 0, 4'h0, 2'd0, 8'h00);
        repeat (4) v(1, 4'hF, 0, 4'h2, 2'd1, 8'hB1);
        v(1, 4'hD, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'hF, 0, 4'h0, 2'd0, 8'h00);
        repeat (4) v(1, 4'hF, 0, 4'h4, 2'd2, 8'hC2);
        v(1, 4'hB, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'hF, 0, 4'h0, 2'd0, 8'h00);
        repeat (4) v(1, 4'hF, 0, 4'h8, 2'd3, 8'hD3);
        v(1, 4'h7, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'hF, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'hF, 0, 4'h1, 2'd0, 8'hA0);
        repeat (3) v(1, 4'h0, 0, 4'h0, 2'd0, 8'h00);
        // Wrap-around: ep2 grant leaves ptr=3, then ep0+ep1 -> ep0, then ep1
        v(1, 4'h4, 0, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h0, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h3, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h3, 0, 4'h1, 2'd0, 8'hA0);
        v(1, 4'h2, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h2, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h2, 0, 4'h2, 2'd1, 8'hB1);
        // PE busy hold on ep2; other requests ignored while granted
        v(1, 4'h0, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h4, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h4, 0, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h4, 1, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h0, 1, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h9, 1, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h9, 1, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h0, 1, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h0, 1, 4'h4, 2'd2, 8'hC2);
        v(1, 4'h0, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h0, 1, 4'h0, 2'd0, 8'h00);
        v(1, 4'h0, 1, 4'h0, 2'd0, 8'h00);
        // Busy does not mask a new grant in IDLE (ptr=3 -> ep1)
        v(1, 4'h2, 1, 4'h2, 2'd1, 8'hB1);
        v(1, 4'h2, 0, 4'h2, 2'd1, 8'hB1);
        // Reset mid-grant on ep3, then ep0 beats ep3
        v(1, 4'h0, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h8, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h8, 0, 4'h8, 2'd3, 8'hD3);
        v(0, 4'h9, 0, 4'h0, 2'd0, 8'h00);
        v(1, 4'h9, 0, 4'h1, 2'd0, 8'hA0);
        v(1, 4'h9, 0, 4'h1, 2'd0, 8'hA0);

        foreach (vq[k]) begin
            logic chk_idx;
            reset_n       = vq[k].rst_n;
            bus.in_ep_req = vq[k].req;
            bus.pe_busy   = vq[k].busy;
            @(posedge clk);
            #1;
            chk_idx = !vq[k].rst_n || (|vq[k].g);
            n_tests++;
            if (bus.in_ep_grant !== vq[k].g || bus.grant_valid !== (|vq[k].g) ||
                bus.arb_in_ep_data !== vq[k].a ||
                (chk_idx && bus.grant_idx !== vq[k].i)) begin
                n_fail++;
                $display("FAIL vec%0d: grant=%b valid=%b idx=%0d data=%h, required grant=%b valid=%b idx=%0d data=%h",
                         k, bus.in_ep_grant, bus.grant_valid, bus.grant_idx, bus.arb_in_ep_data,
                         vq[k].g, |vq[k].g, vq[k].i, vq[k].a);
            end
        end

        // Data follows in_ep_data with no clock edge while ep0 is granted.
        bus.in_ep_data = 32'hD3C2B15A;
        #1;
        n_tests++;
        if (bus.arb_in_ep_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL mux_zero_latency: data=%h, required 5a", bus.arb_in_ep_data);
        end

        // Release: drop req with engine idle; grant must fall on the very next edge.
        bus.in_ep_req = 4'h8;
        n = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            n = c;
            if (!bus.grant_valid) break;
        end
        n_tests++;
        if (bus.grant_valid !== 1'b0 || n != 1) begin
            n_fail++;
            $display("FAIL release_latency: cycles=%0d valid=%b, required cycles=1 valid=0", n, bus.grant_valid);
        end

        // Two grant-free cycles before ep3 is re-granted.
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_gap: valid=%b, required 0", bus.grant_valid);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ep_grant !== 4'h8 || bus.grant_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL regrant_ep3: grant=%b idx=%0d, required grant=1000 idx=3", bus.in_ep_grant, bus.grant_idx);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
